// File: rtl/lockin_pkg.sv
// Shared constants and helpers for the lock-in photon counter.
// Phase boundaries, I/Q sizing and saturating arithmetic.
package lockin_pkg;

    localparam int IQ_SIGN_BITS = 1;

    // Width that holds a signed sum of all phase bins without overflow.
    function automatic int iq_width(input int cnt_w, input int phases);
        return cnt_w + $clog2(phases) + IQ_SIGN_BITS;
    endfunction

    // First phase-timer value belonging to phase bin k.
    function automatic int phase_bound(
        input int period,
        input int phases,
        input int k
    );
        return k * (period / phases);
    endfunction

    // Increment v, holding at 2^w-1 (w <= 32).
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        if ({1'b0, v} >= lim) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/pmt_edge_sync.sv
// PMT discriminator synchroniser with rising-edge detect.
// Emits at most one event per clock.
module pmt_edge_sync
    import lockin_pkg::*;
(
    input  logic clock_50_mhz,
    input  logic reset,
    input  logic pulse_async,
    output logic pulse_event
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pulse_async;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse_event = sync & ~prev;

endmodule

// File: rtl/lockin_photon_counter.sv
// Multi-phase lock-in photon counter with I/Q sums and a
// double-buffered gated arrival-time histogram.
module lockin_photon_counter
    import lockin_pkg::*;
#(
    parameter int MOD_PERIOD_CLKS = 500,
    parameter int NUM_PHASES      = 4,
    parameter int INTEG_PERIODS   = 1000000,
    parameter int CNT_W           = 32,
    parameter int HIST_BINS       = 20,
    parameter int HIST_W          = 9,
    parameter int GATE_START      = 250
) (
    input  logic clock_50_mhz,
    input  logic reset,
    input  logic PMT_in,
    input  logic enable,
    output logic light_source_pin,
    output logic pulse_out_pin,
    output logic frame_valid,
    output logic [15:0] frame_id,
    output logic [NUM_PHASES*CNT_W-1:0] phase_counts,
    output logic signed
        [iq_width(CNT_W, NUM_PHASES)-1:0] i_value,
    output logic signed
        [iq_width(CNT_W, NUM_PHASES)-1:0] q_value,
    input  logic [$clog2(HIST_BINS+1)-1:0] hist_rd_addr,
    output logic [HIST_W-1:0] hist_rd_data
);

    localparam int TW   = $clog2(MOD_PERIOD_CLKS + 1);
    localparam int PW   =
        (INTEG_PERIODS > 1) ? $clog2(INTEG_PERIODS) : 1;
    localparam int IDXW = $clog2(NUM_PHASES);
    localparam int IQW  = iq_width(CNT_W, NUM_PHASES);
    localparam int AW   = $clog2(HIST_BINS + 1);
    localparam int HBW  = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1;

    logic [TW-1:0]   timer;
    logic [PW-1:0]   per_cnt;
    logic            timer_last;
    logic            frame_end;
    logic            pmt_event;
    logic            hit;
    logic            in_gate;
    logic            hit_gate;
    logic [HBW-1:0]  hbin;
    logic [IDXW-1:0] phase_idx;

    pmt_edge_sync u_sync (
        .clock_50_mhz(clock_50_mhz),
        .reset       (reset),
        .pulse_async (PMT_in),
        .pulse_event (pmt_event)
    );

    assign timer_last = timer == TW'(MOD_PERIOD_CLKS - 1);
    assign frame_end  = timer_last
                     && per_cnt == PW'(INTEG_PERIODS - 1);
    assign hit        = pmt_event & enable;
    assign in_gate    = timer >= TW'(GATE_START)
                     && timer < TW'(GATE_START + HIST_BINS);
    assign hit_gate   = hit & in_gate;
    assign hbin       = HBW'(timer - TW'(GATE_START));

    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            timer   <= '0;
            per_cnt <= '0;
        end else if (timer_last) begin
            timer   <= '0;
            per_cnt <= frame_end ? '0 : per_cnt + PW'(1);
        end else begin
            timer   <= timer + TW'(1);
        end
    end

    // Compare chain against precomputed boundaries; no divider.
    always_comb begin
        phase_idx = '0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            if (timer >= TW'(phase_bound(MOD_PERIOD_CLKS,
                                         NUM_PHASES, k))) begin
                phase_idx = IDXW'(k);
            end
        end
    end

    logic [CNT_W-1:0] acc [NUM_PHASES];

    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            phase_counts <= '0;
            for (int k = 0; k < NUM_PHASES; k++) begin
                acc[k] <= '0;
            end
        end else if (frame_end) begin
            // A coincident event opens the new frame at 1.
            for (int k = 0; k < NUM_PHASES; k++) begin
                phase_counts[k*CNT_W +: CNT_W] <= acc[k];
                acc[k] <= (hit && phase_idx == IDXW'(k))
                        ? CNT_W'(1) : '0;
            end
        end else if (hit) begin
            acc[phase_idx] <=
                CNT_W'(sat_inc(32'(acc[phase_idx]), CNT_W));
        end
    end

    logic signed [IQW-1:0] i_sum;
    logic signed [IQW-1:0] q_sum;

    always_comb begin
        i_sum = '0;
        q_sum = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (k < NUM_PHASES / 2) begin
                i_sum = i_sum + $signed(IQW'(acc[k]));
            end else begin
                i_sum = i_sum - $signed(IQW'(acc[k]));
            end
            if (k >= NUM_PHASES / 4
                && k < 3 * NUM_PHASES / 4) begin
                q_sum = q_sum + $signed(IQW'(acc[k]));
            end else begin
                q_sum = q_sum - $signed(IQW'(acc[k]));
            end
        end
    end

    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            light_source_pin <= 1'b0;
            pulse_out_pin    <= 1'b0;
            frame_valid      <= 1'b0;
            frame_id         <= '0;
            i_value          <= '0;
            q_value          <= '0;
        end else begin
            light_source_pin <= timer < TW'(MOD_PERIOD_CLKS / 2);
            pulse_out_pin    <= in_gate;
            frame_valid      <= frame_end;
            if (frame_end) begin
                frame_id <= frame_id + 16'd1;
                i_value  <= i_sum;
                q_value  <= q_sum;
            end
        end
    end

    logic [HIST_W-1:0]    hist_mem [2][HIST_BINS];
    logic [HIST_BINS-1:0] hist_vld [2];
    logic                 bank_sel;
    logic                 rd_bank;

    assign rd_bank = ~bank_sel;

    // Clearing valid bits empties the incoming bank in one cycle.
    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            bank_sel    <= 1'b0;
            hist_vld[0] <= '0;
            hist_vld[1] <= '0;
        end else if (frame_end) begin
            bank_sel          <= rd_bank;
            hist_vld[rd_bank] <= '0;
            if (hit_gate) begin
                hist_vld[rd_bank][hbin] <= 1'b1;
            end
        end else if (hit_gate) begin
            hist_vld[bank_sel][hbin] <= 1'b1;
        end
    end

    always_ff @(posedge clock_50_mhz) begin
        if (!reset && hit_gate) begin
            if (frame_end) begin
                hist_mem[rd_bank][hbin] <= HIST_W'(1);
            end else if (!hist_vld[bank_sel][hbin]) begin
                hist_mem[bank_sel][hbin] <= HIST_W'(1);
            end else begin
                hist_mem[bank_sel][hbin] <= HIST_W'(
                    sat_inc(32'(hist_mem[bank_sel][hbin]), HIST_W));
            end
        end
    end

    logic           rd_in_range;
    logic [HBW-1:0] rd_idx;

    assign rd_in_range = hist_rd_addr < AW'(HIST_BINS);
    assign rd_idx      = HBW'(hist_rd_addr);

    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            hist_rd_data <= '0;
        end else if (rd_in_range && hist_vld[rd_bank][rd_idx]) begin
            hist_rd_data <= hist_mem[rd_bank][rd_idx];
        end else begin
            hist_rd_data <= '0;
        end
    end

endmodule
